vliw_run_ctrl: RTL

- Run/reset sequencer that sits between the top-level clock/reset and a VLIW core.
- Replaces ad-hoc reset toggling with a parametrised, synthesisable sequence: hold reset for a fixed time, then release N reset domains in a staggered order.
- Then runs the core and stops it on a halt request or a cycle-budget timeout.
- Reports completion, timeout and executed cycle count for benches and debug.

---
 rtl/vliw_pkg.sv | 25 ++
 rtl/vliw_rst_stagger.sv | 43 ++++
 rtl/vliw_run_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/vliw_pkg.sv
// Shared types and default constants for the VLIW run/reset sequencer.
// Optional single-step support is enabled with VLIW_RUN_CTRL_STEP_EN.
package vliw_pkg;

  localparam int VLIW_DEF_NUM_DOMAINS = 2;
  localparam int VLIW_DEF_RST_HOLD    = 5;
  localparam int VLIW_DEF_STAGGER     = 1;
  localparam int VLIW_DEF_MAX_RUN     = 1024;
  localparam int VLIW_DEF_CNT_W       = 32;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HOLD    = 3'd1;
  localparam logic [2:0] ST_RELEASE = 3'd2;
  localparam logic [2:0] ST_RUN     = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    HOLD    = ST_HOLD,
    RELEASE = ST_RELEASE,
    RUN     = ST_RUN,
    DONE    = ST_DONE
  } run_state_t;

endpackage

// File: rtl/vliw_rst_stagger.sv
// Staggered per-domain reset release: while i_rel_en is high, one domain
// (lowest index first) is released every STAGGER cycles; released bits stay low.
module vliw_rst_stagger
  import vliw_pkg::*;
#(
  parameter int NUM_DOMAINS = VLIW_DEF_NUM_DOMAINS,
  parameter int STAGGER     = VLIW_DEF_STAGGER
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_restart,
  input  logic                   i_rel_en,
  output logic [NUM_DOMAINS-1:0] o_core_rst
);

  localparam int IDX_W = (NUM_DOMAINS < 2) ? 1 : $clog2(NUM_DOMAINS + 1);
  localparam int STG_W = (STAGGER < 2) ? 1 : $clog2(STAGGER);

  logic [NUM_DOMAINS-1:0] r_core_rst;
  logic [IDX_W-1:0]       r_idx;
  logic [STG_W-1:0]       r_stg;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_restart) begin
      r_core_rst <= '1;
      r_idx      <= '0;
      r_stg      <= '0;
    end else if (i_rel_en) begin
      if (r_stg == '0) begin
        for (int i = 0; i < NUM_DOMAINS; i++) begin
          if (r_idx == IDX_W'(i)) r_core_rst[i] <= 1'b0;
        end
        r_idx <= r_idx + IDX_W'(1);
        r_stg <= STG_W'(STAGGER - 1);
      end else begin
        r_stg <= r_stg - STG_W'(1);
      end
    end
  end

  assign o_core_rst = r_core_rst;

endmodule

// File: rtl/vliw_run_ctrl.sv
// Run/reset sequencer for a VLIW core: hold, staggered release, budgeted run.
// Define VLIW_RUN_CTRL_STEP_EN to add single-step inputs i_step_mode / i_step.
module vliw_run_ctrl
  import vliw_pkg::*;
#(
  parameter int NUM_DOMAINS = VLIW_DEF_NUM_DOMAINS,
  parameter int RST_HOLD    = VLIW_DEF_RST_HOLD,
  parameter int STAGGER     = VLIW_DEF_STAGGER,
  parameter int MAX_RUN     = VLIW_DEF_MAX_RUN,
  parameter int CNT_W       = VLIW_DEF_CNT_W
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_halt_req,
`ifdef VLIW_RUN_CTRL_STEP_EN
  input  logic                   i_step_mode,
  input  logic                   i_step,
`endif
  output logic [NUM_DOMAINS-1:0] o_core_rst,
  output logic                   o_run,
  output logic                   o_done,
  output logic                   o_timeout,
  output logic [CNT_W-1:0]       o_cycle_count
);

  // state   | meaning
  // IDLE    | all domains in reset, waiting for start
  // HOLD    | all domains in reset for RST_HOLD cycles
  // RELEASE | domains released one by one, STAGGER cycles apart
  // RUN     | core executing, counting run cycles against the budget
  // DONE    | stopped by halt or budget; results held for inspection

  if (NUM_DOMAINS < 1 || RST_HOLD < 1 || STAGGER < 1) begin : g_bad_param
    $error("vliw_run_ctrl: NUM_DOMAINS, RST_HOLD and STAGGER must be >= 1");
  end

  localparam int REL_LEN = NUM_DOMAINS * STAGGER;
  localparam int TMR_MAX = (RST_HOLD > REL_LEN) ? RST_HOLD : REL_LEN;
  localparam int TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);
  localparam int BUD_W   = (MAX_RUN < 2) ? 1 : $clog2(MAX_RUN + 1);

  run_state_t       r_state;
  logic [TMR_W-1:0] r_tmr;
  logic [BUD_W-1:0] r_budget;
  logic             r_run;
  logic             r_done;
  logic             r_timeout;
  logic [CNT_W-1:0] r_cnt;

  logic             w_run_next;
  logic             w_rel_en;
  logic             w_restart;
  logic [CNT_W-1:0] w_cnt_inc;

`ifdef VLIW_RUN_CTRL_STEP_EN
  assign w_run_next = i_step_mode ? i_step : 1'b1;
`else
  assign w_run_next = 1'b1;
`endif

  // release enable is high in every cycle whose successor is a RELEASE cycle
  assign w_rel_en  = ((r_state == HOLD) && (r_tmr == '0)) ||
                     ((r_state == RELEASE) && (r_tmr != '0));
  assign w_restart = (r_state == IDLE) || ((r_state == DONE) && i_start);
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_tmr     <= '0;
      r_budget  <= '0;
      r_run     <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= HOLD;
            r_tmr   <= TMR_W'(RST_HOLD - 1);
          end
        end
        HOLD: begin
          if (r_tmr == '0) begin
            r_state <= RELEASE;
            r_tmr   <= TMR_W'(REL_LEN - 1);
          end else begin
            r_tmr <= r_tmr - TMR_W'(1);
          end
        end
        RELEASE: begin
          if (r_tmr == '0) begin
            r_state  <= RUN;
            r_run    <= w_run_next;
            r_budget <= BUD_W'(MAX_RUN);
          end else begin
            r_tmr <= r_tmr - TMR_W'(1);
          end
        end
        RUN: begin
          if (r_run) begin
            r_cnt    <= w_cnt_inc;
            r_budget <= r_budget - BUD_W'(1);
            // halt takes priority over a budget expiry in the same cycle
            if (i_halt_req) begin
              r_state   <= DONE;
              r_run     <= 1'b0;
              r_done    <= 1'b1;
              r_timeout <= 1'b0;
            end else if ((MAX_RUN != 0) && (r_budget == BUD_W'(1))) begin
              r_state   <= DONE;
              r_run     <= 1'b0;
              r_done    <= 1'b1;
              r_timeout <= 1'b1;
            end else begin
              r_run <= w_run_next;
            end
          end else begin
            r_run <= w_run_next;
          end
        end
        DONE: begin
          if (i_start) begin
            r_state   <= HOLD;
            r_tmr     <= TMR_W'(RST_HOLD - 1);
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  vliw_rst_stagger #(
    .NUM_DOMAINS (NUM_DOMAINS),
    .STAGGER     (STAGGER)
  ) u_stagger (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_restart  (w_restart),
    .i_rel_en   (w_rel_en),
    .o_core_rst (o_core_rst)
  );

  assign o_run         = r_run;
  assign o_done        = r_done;
  assign o_timeout     = r_timeout;
  assign o_cycle_count = r_cnt;

endmodule
